// File: rtl/ram_sdp_be_pkg.sv
// ram_pkg: shared definitions for the ram_sdp_be simple-dual-port RAM.
//   - RDW_OLD / RDW_NEW : read-during-write policy selectors
//   - init_state_e      : clear-sequencer state encoding
//   - clog2             : ceiling log2 for parameter checks
//   - lane_count        : number of write-enable lanes, ceil(w / l)
package ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } init_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int lane_count(input int w, input int l);
        return (w + l - 1) / l;
    endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: bus bundle between a RAM client (master) and ram_sdp_be (slave).
//   write port : wr_enb, wr_addr, wr_data, wr_be
//   read port  : rd_enb, rd_addr -> rd_data, rd_valid
//   clear      : init_req -> init_busy
interface ram_sdp_be_if
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH  = 22,
    parameter int ADDR_SIZE  = 10,
    parameter int LANE_WIDTH = 8,
    parameter int BE_WIDTH   = lane_count(RAM_WIDTH, LANE_WIDTH)
);

    logic                 wr_enb;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [RAM_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]  wr_be;
    logic                 rd_enb;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [RAM_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 init_req;
    logic                 init_busy;

    modport master (
        output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr, init_req,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr, init_req,
        output rd_data, rd_valid, init_busy
    );

endinterface

// File: rtl/ram_sdp_be_init_seq.sv
// ram_init_seq: clear sequencer. After reset, or on init_req while idle,
// walks clr_addr from 0 to RAM_DEPTH-1 issuing one zero-write per cycle.
//   clk, rst_n   : clock, async active-low reset (reset starts a clear)
//   init_req_i   : request a new clear (ignored while clearing)
//   clr_we_o     : clear write strobe
//   clr_addr_o   : clear write address
//   init_busy_o  : high while clearing (and in reset)
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_req_i,
    output logic                 clr_we_o,
    output logic [ADDR_SIZE-1:0] clr_addr_o,
    output logic                 init_busy_o
);

    init_state_e          state_q, state_d;
    logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
    logic                 last_s;

    assign last_s = (32'(clr_addr_q) == 32'(RAM_DEPTH - 1));

    // Next-state and clear-address logic
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (last_s) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_SIZE'(1);
                end
            end
            ST_IDLE: begin
                if (init_req_i) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // State and clear-address registers; reset always begins a fresh clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clr_we_o    = (state_q == ST_CLEAR);
    assign clr_addr_o  = clr_addr_q;
    assign init_busy_o = (state_q == ST_CLEAR);

endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with per-lane write enables, read latency
// of 1 or 2, selectable read-during-write policy and a post-reset clear.
//   clk, rst_n : clock, async active-low reset
//   bus        : ram_sdp_be_if slave (write port, read port, init_req/init_busy)
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH  = 22,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_SIZE  = 10,
    parameter int LANE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_OLD
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sdp_be_if.slave  bus
);

    localparam int BE_WIDTH = lane_count(RAM_WIDTH, LANE_WIDTH);

    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
    end
    if ((RDW_MODE != RDW_OLD) && (RDW_MODE != RDW_NEW)) begin : g_bad_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end
    if (ADDR_SIZE < clog2(RAM_DEPTH)) begin : g_bad_addr
        $error("ram_sdp_be: ADDR_SIZE too small for RAM_DEPTH");
    end

    function automatic logic [RAM_WIDTH-1:0] merge_lanes(
        input logic [RAM_WIDTH-1:0] old_w,
        input logic [RAM_WIDTH-1:0] new_w,
        input logic [RAM_WIDTH-1:0] mask
    );
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                 clr_we_s;
    logic [ADDR_SIZE-1:0] clr_addr_s;
    logic                 busy_s;
    logic [RAM_WIDTH-1:0] lane_mask_s;
    logic                 wr_fire_s;
    logic                 rd_fire_s;
    logic                 rd_in_range_s;
    logic                 rdw_hit_s;
    logic                 mem_we_s;
    logic [ADDR_SIZE-1:0] mem_addr_s;
    logic [RAM_WIDTH-1:0] mem_wdata_s;
    logic [RAM_WIDTH-1:0] mem_mask_s;
    logic [RAM_WIDTH-1:0] rd_word_s;
    logic                 stg_valid_s;
    logic [RAM_WIDTH-1:0] stg_data_s;
    logic                 rd_valid_q;
    logic [RAM_WIDTH-1:0] rd_data_q;

    ram_init_seq #(
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_init_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req_i  (bus.init_req),
        .clr_we_o    (clr_we_s),
        .clr_addr_o  (clr_addr_s),
        .init_busy_o (busy_s)
    );

    // Expand lane enables to a per-bit mask; the loop bound clips the last lane
    always_comb begin
        lane_mask_s = '0;
        for (int b = 0; b < RAM_WIDTH; b++) begin
            lane_mask_s[b] = bus.wr_be[b / LANE_WIDTH];
        end
    end

    assign rd_in_range_s = (32'(bus.rd_addr) < 32'(RAM_DEPTH));
    assign wr_fire_s     = bus.wr_enb & ~busy_s & (32'(bus.wr_addr) < 32'(RAM_DEPTH));
    assign rd_fire_s     = bus.rd_enb & ~busy_s;
    assign rdw_hit_s     = (RDW_MODE == RDW_NEW) && wr_fire_s && (bus.wr_addr == bus.rd_addr);

    // Write-port mux: the clear sequencer owns the port while busy
    always_comb begin
        if (clr_we_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_s;
            mem_wdata_s = '0;
            mem_mask_s  = '1;
        end else begin
            mem_we_s    = wr_fire_s;
            mem_addr_s  = bus.wr_addr;
            mem_wdata_s = bus.wr_data;
            mem_mask_s  = lane_mask_s;
        end
    end

    // Storage array, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= merge_lanes(mem_q[mem_addr_s], mem_wdata_s, mem_mask_s);
        end
    end

    // Read word selection: out-of-range reads give 0; new-data policy bypasses the write
    always_comb begin
        rd_word_s = '0;
        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if (rdw_hit_s) begin
            rd_word_s = merge_lanes(mem_q[bus.rd_addr], bus.wr_data, lane_mask_s);
        end else begin
            rd_word_s = mem_q[bus.rd_addr];
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 s1_valid_q;
        logic [RAM_WIDTH-1:0] s1_data_q;

        // Extra pipeline stage for two-cycle latency
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_fire_s;
                if (rd_fire_s) begin
                    s1_data_q <= rd_word_s;
                end
            end
        end

        assign stg_valid_s = s1_valid_q;
        assign stg_data_s  = s1_data_q;
    end else begin : g_lat1
        assign stg_valid_s = rd_fire_s;
        assign stg_data_s  = rd_word_s;
    end

    // Output register: data holds between results, valid pulses per result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= stg_valid_s;
            if (stg_valid_s) begin
                rd_data_q <= stg_data_s;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = busy_s;

endmodule

// File: tb/tb_ram_sdp_be.sv
module tb_ram_sdp_be;
    import ram_pkg::*;

    localparam int W  = 22;
    localparam int A  = 10;
    localparam int L  = 8;
    localparam int D0 = 1024;
    localparam int D1 = 1000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [W-1:0] obs_data  [2];
    logic         obs_valid [2];
    logic         obs_busy  [2];
    int           fall_cnt  [2];
    logic         stray     [2];
    int           exp_fall  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_sdp_be_if #(.RAM_WIDTH(W), .ADDR_SIZE(A), .LANE_WIDTH(L)) bus0 ();
    ram_sdp_be_if #(.RAM_WIDTH(W), .ADDR_SIZE(A), .LANE_WIDTH(L)) bus1 ();

    ram_sdp_be #(.RAM_WIDTH(W), .RAM_DEPTH(D0), .ADDR_SIZE(A), .LANE_WIDTH(L),
                 .RD_LATENCY(1), .RDW_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    ram_sdp_be #(.RAM_WIDTH(W), .RAM_DEPTH(D1), .ADDR_SIZE(A), .LANE_WIDTH(L),
                 .RD_LATENCY(2), .RDW_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign obs_data[0]  = bus0.rd_data;
    assign obs_data[1]  = bus1.rd_data;
    assign obs_valid[0] = bus0.rd_valid;
    assign obs_valid[1] = bus1.rd_valid;
    assign obs_busy[0]  = bus0.init_busy;
    assign obs_busy[1]  = bus1.init_busy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int d, input logic en, input logic [A-1:0] addr,
                          input logic [W-1:0] data, input logic [2:0] be);
        if (d == 0) begin
            bus0.wr_enb = en; bus0.wr_addr = addr; bus0.wr_data = data; bus0.wr_be = be;
        end else begin
            bus1.wr_enb = en; bus1.wr_addr = addr; bus1.wr_data = data; bus1.wr_be = be;
        end
    endtask

    task automatic set_rd(input int d, input logic en, input logic [A-1:0] addr);
        if (d == 0) begin
            bus0.rd_enb = en; bus0.rd_addr = addr;
        end else begin
            bus1.rd_enb = en; bus1.rd_addr = addr;
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            set_wr(d, 1'b0, '0, '0, 3'b000);
            set_rd(d, 1'b0, '0);
        end
        bus0.init_req = 1'b0;
        bus1.init_req = 1'b0;
    endtask

    task automatic write_both(input logic [A-1:0] addr, input logic [W-1:0] data,
                              input logic [2:0] be);
        set_wr(0, 1'b1, addr, data, be);
        set_wr(1, 1'b1, addr, data, be);
        step();
        set_wr(0, 1'b0, '0, '0, 3'b000);
        set_wr(1, 1'b0, '0, '0, 3'b000);
    endtask

    // dut0 answers at the sampling edge, dut1 one edge later
    task automatic read_both(input logic [A-1:0] addr,
                             output logic [W-1:0] q0, output logic v0,
                             output logic [W-1:0] q1, output logic v1);
        set_rd(0, 1'b1, addr);
        set_rd(1, 1'b1, addr);
        step();
        set_rd(0, 1'b0, '0);
        set_rd(1, 1'b0, '0);
        q0 = obs_data[0];
        v0 = obs_valid[0];
        step();
        q1 = obs_data[1];
        v1 = obs_valid[1];
        step();
    endtask

    // Count edges until each DUT drops init_busy, noting any rd_valid while busy
    task automatic wait_clear();
        int cnt;
        cnt = 0;
        for (int d = 0; d < 2; d++) begin
            fall_cnt[d] = 0;
            stray[d]    = 1'b0;
        end
        while (((fall_cnt[0] == 0) || (fall_cnt[1] == 0)) && (cnt < 1100)) begin
            step();
            cnt++;
            for (int d = 0; d < 2; d++) begin
                if (fall_cnt[d] == 0) begin
                    if (obs_valid[d] !== 1'b0) stray[d] = 1'b1;
                    if (obs_busy[d] === 1'b0) begin
                        fall_cnt[d] = cnt;
                        set_rd(d, 1'b0, '0);
                        set_wr(d, 1'b0, '0, '0, 3'b000);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_rd(d, 1'b1, 10'd0);
            set_wr(d, 1'b1, 10'd0, 22'h3FFFFF, 3'b111);
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_data[d] !== 22'd0 || obs_valid[d] !== 1'b0 || obs_busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d got data=%h valid=%b busy=%b exp 000000 0 1",
                         d, obs_data[d], obs_valid[d], obs_busy[d]);
            end
        end
        rst_n = 1'b1;
        wait_clear();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fall_cnt[d] !== exp_fall[d]) begin
                errors++;
                $display("FAIL reset_clear_len dut%0d got %0d exp %0d", d, fall_cnt[d], exp_fall[d]);
            end
            checks++;
            if (stray[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_valid_busy dut%0d got stray=%b exp 0", d, stray[d]);
            end
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_read_latency();
        logic [A-1:0] addrs [3];
        addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
        for (int i = 0; i < 3; i++) begin
            set_rd(0, 1'b1, addrs[i]);
            set_rd(1, 1'b1, addrs[i]);
            step();
            set_rd(0, 1'b0, '0);
            set_rd(1, 1'b0, '0);
            checks++;
            if (obs_valid[0] !== 1'b1 || obs_data[0] !== 22'd0) begin
                errors++;
                $display("FAIL lat1_edge_n addr %0d got v=%b d=%h exp v=1 d=000000",
                         addrs[i], obs_valid[0], obs_data[0]);
            end
            checks++;
            if (obs_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL lat2_early addr %0d got v=%b exp v=0", addrs[i], obs_valid[1]);
            end
            step();
            checks++;
            if (obs_valid[1] !== 1'b1 || obs_data[1] !== 22'd0) begin
                errors++;
                $display("FAIL lat2_edge_n1 addr %0d got v=%b d=%h exp v=1 d=000000",
                         addrs[i], obs_valid[1], obs_data[1]);
            end
            checks++;
            if (obs_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL lat1_pulse addr %0d got v=%b exp v=0", addrs[i], obs_valid[0]);
            end
            step();
            checks++;
            if (obs_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL lat2_pulse addr %0d got v=%b exp v=0", addrs[i], obs_valid[1]);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [W-1:0] q0, q1;
        logic         v0, v1;
        write_both(10'd5, 22'h3FFFFF, 3'b111);
        write_both(10'd5, 22'h000000, 3'b010);
        write_both(10'd5, 22'h123456, 3'b000);
        read_both(10'd5, q0, v0, q1, v1);
        checks++;
        if (q0 !== 22'h3F00FF || v0 !== 1'b1) begin
            errors++;
            $display("FAIL byte_lanes dut0 got %h v=%b exp 3f00ff v=1", q0, v0);
        end
        checks++;
        if (q1 !== 22'h3F00FF || v1 !== 1'b1) begin
            errors++;
            $display("FAIL byte_lanes dut1 got %h v=%b exp 3f00ff v=1", q1, v1);
        end
    endtask

    task automatic test_rdw();
        logic [W-1:0] q0, q1;
        logic         v0, v1;
        write_both(10'd7, 22'h000011, 3'b111);
        for (int d = 0; d < 2; d++) begin
            set_wr(d, 1'b1, 10'd7, 22'h2AAAAA, 3'b101);
            set_rd(d, 1'b1, 10'd7);
        end
        step();
        idle_all();
        checks++;
        if (obs_data[0] !== 22'h000011 || obs_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL rdw_old dut0 got %h v=%b exp 000011 v=1", obs_data[0], obs_valid[0]);
        end
        step();
        checks++;
        if (obs_data[1] !== 22'h2A00AA || obs_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL rdw_new dut1 got %h v=%b exp 2a00aa v=1", obs_data[1], obs_valid[1]);
        end
        step();
        read_both(10'd7, q0, v0, q1, v1);
        checks++;
        if (q0 !== 22'h2A00AA || q1 !== 22'h2A00AA) begin
            errors++;
            $display("FAIL rdw_after got dut0=%h dut1=%h exp 2a00aa", q0, q1);
        end
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] q0, q1;
        logic         v0, v1;
        write_both(10'd999, 22'h0ABCDE, 3'b111);
        write_both(10'd1010, 22'h155555, 3'b111);
        read_both(10'd1010, q0, v0, q1, v1);
        checks++;
        if (q0 !== 22'h155555 || v0 !== 1'b1) begin
            errors++;
            $display("FAIL inrange_1010 dut0 got %h v=%b exp 155555 v=1", q0, v0);
        end
        checks++;
        if (q1 !== 22'h000000 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL oor_read dut1 got %h v=%b exp 000000 v=1", q1, v1);
        end
        read_both(10'd999, q0, v0, q1, v1);
        checks++;
        if (q0 !== 22'h0ABCDE || q1 !== 22'h0ABCDE) begin
            errors++;
            $display("FAIL oor_neighbour got dut0=%h dut1=%h exp 0abcde", q0, q1);
        end
    endtask

    task automatic test_back_to_back();
        logic [A-1:0] ord [3];
        logic [W-1:0] seq [3];
        logic         ev;
        write_both(10'd0, 22'h000111, 3'b111);
        write_both(10'd1, 22'h000222, 3'b111);
        write_both(10'd2, 22'h000333, 3'b111);
        ord[0] = 10'd2;       ord[1] = 10'd0;       ord[2] = 10'd1;
        seq[0] = 22'h000333;  seq[1] = 22'h000111;  seq[2] = 22'h000222;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                set_rd(0, 1'b1, ord[k]);
                set_rd(1, 1'b1, ord[k]);
            end else begin
                set_rd(0, 1'b0, '0);
                set_rd(1, 1'b0, '0);
            end
            step();
            ev = (k < 3);
            checks++;
            if (obs_valid[0] !== ev || (ev && obs_data[0] !== seq[k])) begin
                errors++;
                $display("FAIL b2b_lat1 edge %0d got v=%b d=%h exp v=%b d=%h",
                         k, obs_valid[0], obs_data[0], ev, (k < 3) ? seq[k] : 22'd0);
            end
            ev = (k >= 1) && (k <= 3);
            checks++;
            if (obs_valid[1] !== ev || (ev && obs_data[1] !== seq[k-1])) begin
                errors++;
                $display("FAIL b2b_lat2 edge %0d got v=%b d=%h exp v=%b d=%h",
                         k, obs_valid[1], obs_data[1], ev, ev ? seq[k-1] : 22'd0);
            end
        end
    endtask

    task automatic test_init_req();
        logic [W-1:0] q0, q1;
        logic         v0, v1;
        for (int i = 0; i < 10; i++) begin
            write_both(A'(i), W'((i + 1) * 22'h010203), 3'b111);
        end
        bus0.init_req = 1'b1;
        bus1.init_req = 1'b1;
        step();
        bus0.init_req = 1'b0;
        bus1.init_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL init_busy_rise dut%0d got %b exp 1", d, obs_busy[d]);
            end
            set_rd(d, 1'b1, 10'd3);
            set_wr(d, 1'b1, 10'd4, 22'h3FFFFF, 3'b111);
        end
        wait_clear();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fall_cnt[d] !== exp_fall[d]) begin
                errors++;
                $display("FAIL init_clear_len dut%0d got %0d exp %0d", d, fall_cnt[d], exp_fall[d]);
            end
            checks++;
            if (stray[d] !== 1'b0) begin
                errors++;
                $display("FAIL init_no_valid_busy dut%0d got stray=%b exp 0", d, stray[d]);
            end
        end
        idle_all();
        step();
        for (int i = 0; i < 10; i++) begin
            read_both(A'(i), q0, v0, q1, v1);
            checks++;
            if (q0 !== 22'd0 || q1 !== 22'd0 || v0 !== 1'b1 || v1 !== 1'b1) begin
                errors++;
                $display("FAIL init_cleared addr %0d got dut0=%h/%b dut1=%h/%b exp 000000/1",
                         i, q0, v0, q1, v1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q0, q1;
        logic         v0, v1;
        write_both(10'd3, 22'h0000AB, 3'b111);
        set_rd(0, 1'b1, 10'd3);
        set_rd(1, 1'b1, 10'd3);
        step();
        idle_all();
        checks++;
        if (obs_data[0] !== 22'h0000AB || obs_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_setup dut0 got %h v=%b exp 0000ab v=1", obs_data[0], obs_valid[0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_data[d] !== 22'd0 || obs_valid[d] !== 1'b0 || obs_busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL mid_read_reset dut%0d got data=%h valid=%b busy=%b exp 000000 0 1",
                         d, obs_data[d], obs_valid[d], obs_busy[d]);
            end
        end
        step();
        rst_n = 1'b1;
        repeat (300) step();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_busy[d] !== 1'b1 || obs_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL mid_clear_reset dut%0d got busy=%b valid=%b exp 1 0",
                         d, obs_busy[d], obs_valid[d]);
            end
        end
        step();
        rst_n = 1'b1;
        wait_clear();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fall_cnt[d] !== exp_fall[d] || stray[d] !== 1'b0) begin
                errors++;
                $display("FAIL rerun_clear dut%0d got len=%0d stray=%b exp len=%0d stray=0",
                         d, fall_cnt[d], stray[d], exp_fall[d]);
            end
        end
        idle_all();
        step();
        read_both(10'd3, q0, v0, q1, v1);
        checks++;
        if (q0 !== 22'd0 || q1 !== 22'd0) begin
            errors++;
            $display("FAIL rerun_wiped got dut0=%h dut1=%h exp 000000", q0, q1);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_fall[0] = D0;
        exp_fall[1] = D1;
        rst_n       = 1'b1;
        test_reset();
        test_read_latency();
        test_byte_lanes();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_init_req();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
